// File: rtl/pipelined_left_shifter.sv
// Pipelined logical-left / rotate-left barrel shifter, one stage per shift-amount bit,
// with valid/ready flow control and bubble-collapsing stall behaviour.
module pipelined_left_shifter #(
    parameter int  DATA_WIDTH  = 32,
    localparam int SHAMT_WIDTH = $clog2(DATA_WIDTH)
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   ivalid,
    output logic                   iready,
    input  logic [DATA_WIDTH-1:0]  idata,
    input  logic [SHAMT_WIDTH-1:0] ishamt,
    input  logic                   irot,
    output logic                   ovalid,
    input  logic                   oready,
    output logic [DATA_WIDTH-1:0]  odata
);

    localparam int S = SHAMT_WIDTH;

    genvar gi;
    generate
        for (gi = 0; gi < S; gi++) begin : g_stage
            localparam int AMT = 2 ** gi;
            // Shift bits still pending when entering this stage, bit 0 is the one applied here.
            localparam int UPW = S - gi;

            logic                  up_v;
            logic                  up_r;
            logic [UPW-1:0]        up_s;
            logic [DATA_WIDTH-1:0] up_d;
            logic [DATA_WIDTH-1:0] lsh;
            logic [DATA_WIDTH-1:0] rot;
            logic [DATA_WIDTH-1:0] shifted;
            logic                  rdy;
            logic                  next_rdy;
            logic                  v_reg;
            logic [DATA_WIDTH-1:0] d_reg;

            if (gi == 0) begin : g_head
                assign up_v = ivalid;
                assign up_d = idata;
                assign up_s = ishamt;
                assign up_r = irot;
            end else begin : g_link
                assign up_v = g_stage[gi-1].v_reg;
                assign up_d = g_stage[gi-1].d_reg;
                assign up_s = g_stage[gi-1].g_ctl.s_reg;
                assign up_r = g_stage[gi-1].g_ctl.r_reg;
            end

            if (gi == S - 1) begin : g_tail
                assign next_rdy = oready;
            end else begin : g_mid
                assign next_rdy = g_stage[gi+1].rdy;
            end

            // An empty stage always accepts, so bubbles are squeezed out during a stall.
            assign rdy     = ~v_reg | next_rdy;
            assign lsh     = up_d << AMT;
            assign rot     = {up_d[DATA_WIDTH-1-AMT:0], up_d[DATA_WIDTH-1 -: AMT]};
            assign shifted = up_s[0] ? (up_r ? rot : lsh) : up_d;

            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    v_reg <= 1'b0;
                    d_reg <= '0;
                end else if (rdy) begin
                    v_reg <= up_v;
                    if (up_v) begin
                        d_reg <= shifted;
                    end
                end
            end

            // The last stage has no remaining shift bits and no further use for the mode flag.
            if (gi < S - 1) begin : g_ctl
                logic [UPW-2:0] s_reg;
                logic           r_reg;

                always_ff @(posedge clk or negedge rstn) begin
                    if (!rstn) begin
                        s_reg <= '0;
                        r_reg <= 1'b0;
                    end else if (rdy && up_v) begin
                        s_reg <= up_s[UPW-1:1];
                        r_reg <= up_r;
                    end
                end
            end
        end
    endgenerate

    assign iready = g_stage[0].rdy;
    assign ovalid = g_stage[S-1].v_reg;
    assign odata  = g_stage[S-1].d_reg;

endmodule

// File: tb/tb_pipelined_left_shifter.sv
// Randomised and directed bench for pipelined_left_shifter, scored against a
// queue-based reference that computes each result arithmetically.
module tb_pipelined_left_shifter;

    logic        clk    = 1'b0;
    logic        rstn   = 1'b0;
    logic        ivalid = 1'b0;
    logic        irot   = 1'b0;
    logic        oready = 1'b1;
    logic        iready;
    logic        ovalid;
    logic [31:0] idata  = 32'h0;
    logic [4:0]  ishamt = 5'd0;
    logic [31:0] odata;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          n_out = 0;
    logic [31:0] want_q[$];
    logic        stall_prev = 1'b0;
    logic [31:0] data_prev  = 32'h0;

    always #5 clk = ~clk;

    pipelined_left_shifter #(.DATA_WIDTH(32)) dut (
        .clk    (clk),
        .rstn   (rstn),
        .ivalid (ivalid),
        .iready (iready),
        .idata  (idata),
        .ishamt (ishamt),
        .irot   (irot),
        .ovalid (ovalid),
        .oready (oready),
        .odata  (odata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_cmp++;
        if (obs !== want) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, obs, want);
        end
    endtask

    // Rotation is the upper half of a doubled word shifted left; a logical
    // shift is the same with zeros in the lower half.
    function automatic logic [31:0] ref_shift(input logic [31:0] d, input logic [4:0] sh,
                                              input logic rot);
        logic [63:0] ext;
        ext = rot ? {d, d} : {d, 32'h0};
        ext = ext << sh;
        return ext[63:32];
    endfunction

    // Scoreboard and protocol monitor, sampled mid-cycle.
    always @(negedge clk) begin
        logic [31:0] want;
        if (!rstn) begin
            want_q.delete();
            stall_prev = 1'b0;
            chk("rst_ovalid", 32'(ovalid), 32'd0);
            chk("rst_odata", odata, 32'h0);
            chk("rst_iready", 32'(iready), 32'd1);
        end else begin
            chk("iready", 32'(iready), 32'(!(want_q.size() == 5 && !oready)));
            if (stall_prev) begin
                chk("stall_ovalid", 32'(ovalid), 32'd1);
                chk("stall_odata", odata, data_prev);
            end
            stall_prev = ovalid && !oready;
            data_prev  = odata;
            if (ovalid && oready) begin
                if (want_q.size() == 0) begin
                    chk("spurious_out", 32'(ovalid), 32'd0);
                end else begin
                    want = want_q.pop_front();
                    chk("out_data", odata, want);
                    $display("out %0d: data=%h expected=%h", n_out, odata, want);
                    n_out++;
                end
            end
            if (ivalid && iready) begin
                want_q.push_back(ref_shift(idata, ishamt, irot));
            end
        end
    end

    task automatic send_vec(input logic [31:0] d, input logic [4:0] sh, input logic rot,
                            input logic [31:0] want);
        int lat;
        @(posedge clk); #1;
        oready = 1'b1;
        ivalid = 1'b1;
        idata  = d;
        ishamt = sh;
        irot   = rot;
        @(posedge clk); #1;
        ivalid = 1'b0;
        lat = 1;
        while (!ovalid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("latency", 32'(lat), 32'd5);
        chk("vec_data", odata, want);
    endtask

    task automatic drain(input string tag);
        int t;
        ivalid = 1'b0;
        oready = 1'b1;
        t = 0;
        while (want_q.size() != 0 && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        chk(tag, 32'(want_q.size()), 32'd0);
    endtask

    initial begin
        // Reset with a word presented; it must be discarded.
        ivalid = 1'b1;
        idata  = 32'hA5A5A5A5;
        repeat (3) @(posedge clk);
        #1;
        rstn   = 1'b1;
        ivalid = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
            chk("idle_ovalid", 32'(ovalid), 32'd0);
        end

        send_vec(32'h00000001, 5'd31, 1'b0, 32'h80000000);
        send_vec(32'hF0F0F0F0, 5'd4,  1'b0, 32'h0F0F0F00);
        send_vec(32'h12345678, 5'd0,  1'b0, 32'h12345678);
        send_vec(32'h80000001, 5'd1,  1'b1, 32'h00000003);
        send_vec(32'hDEADBEEF, 5'd16, 1'b1, 32'hBEEFDEAD);
        send_vec(32'h00000001, 5'd31, 1'b1, 32'h80000000);

        // Back-to-back streaming.
        @(posedge clk); #1;
        oready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            ivalid = 1'b1;
            idata  = $urandom();
            ishamt = 5'($urandom_range(0, 31));
            irot   = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            if (i >= 4) chk("stream_ovalid", 32'(ovalid), 32'd1);
        end
        drain("stream_drain");

        // Random valid and backpressure.
        for (int c = 0; c < 2000; c++) begin
            ivalid = 1'($urandom_range(0, 1));
            idata  = $urandom();
            ishamt = 5'($urandom_range(0, 31));
            irot   = 1'($urandom_range(0, 1));
            oready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        drain("bp_drain");

        // Three words stalled in the pipe, then an asynchronous reset between edges.
        oready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ivalid = 1'b1;
            idata  = $urandom();
            ishamt = 5'($urandom_range(0, 31));
            irot   = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        ivalid = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
        end
        chk("pre_rst_ovalid", 32'(ovalid), 32'd1);
        #2;
        rstn = 1'b0;
        #1;
        chk("async_rst_ovalid", 32'(ovalid), 32'd0);
        chk("async_rst_odata", odata, 32'h0);
        @(posedge clk); #1;
        rstn   = 1'b1;
        oready = 1'b1;
        repeat (10) begin
            @(posedge clk); #1;
            chk("post_rst_ovalid", 32'(ovalid), 32'd0);
        end
        send_vec(32'h000000FF, 5'd8, 1'b1, 32'h0000FF00);
        drain("final_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/pipelined_left_shifter.md
# pipelined_left_shifter

Registered, fully pipelined logical-left / rotate-left barrel shifter with valid/ready flow control on both sides. One shift stage per shift-amount bit, each stage followed by a pipeline register, giving one result per cycle at DATA_WIDTH=32 speeds. It sits on the opposite side of the datapath from the arithmetic right-shift stages, providing left shifts for the ALU and the address/field-insert logic.

## Interface
- DATA_WIDTH, 32: data word width; must be a power of two and at least 2.
- SHAMT_WIDTH, $clog2(DATA_WIDTH) (5): shift-amount width and number of pipeline stages S. It is derived and must not be overridden.
- CLK  input  1  clock; all state updates on the rising edge.
- RSTN  input  1  reset; asynchronous, active-low.
- IVALID  input  1  input word valid.
- IREADY  output  1  block can accept the input word this cycle.
- IDATA  input  DATA_WIDTH  word to shift.
- ISHAMT  input  SHAMT_WIDTH  unsigned left shift amount, 0..DATA_WIDTH-1.
- IROT  input  1  0 = logical shift, zero fill from the LSB; 1 = rotate, bits leaving the MSB re-enter at the LSB.
- OVALID  output  1  result valid.
- OREADY  input  1  downstream accepts the result.
- ODATA  output  DATA_WIDTH  shifted result.

## Operation
- Stages k = 1..S each hold these registers:
  - v_k: valid flag.
  - d_k: data, DATA_WIDTH bits.
  - s_k: remaining shift bits, k..S-1.
  - r_k: rotate flag.
- Stage k applies a shift of 2^(k-1) when bit k-1 of the shift amount is 1, otherwise a pass-through.
- Stage 1 takes its data from IDATA, ISHAMT and IROT. Stage k > 1 takes them from stage k-1.
- Logical shift: d_k = d_{k-1} << 2^(k-1), with vacated LSBs set to 0.
- Rotate: d_k = {d_{k-1}[W-1-2^(k-1):0], d_{k-1}[W-1:W-2^(k-1)]}.
- Ready chain, combinational:
  - rdy_{S+1} = OREADY.
  - rdy_k = ~v_k | rdy_{k+1}.
  - IREADY = rdy_1.
  - Empty stages absorb bubbles, so a stall collapses gaps.
- Stage load: when rdy_k = 1, stage k loads from its upstream. v_k takes upstream valid: IVALID for k = 1, v_{k-1} for k > 1. When rdy_k = 0, stage k holds all of its registers.
- Data registers load only when the upstream valid is 1; otherwise they hold their last value.
- Outputs: OVALID = v_S, ODATA = d_S.
- Input transfer occurs on IVALID & IREADY. Output transfer occurs on OVALID & OREADY.
- ISHAMT = 0 passes IDATA through unchanged in either mode.
- A result is never dropped or duplicated. Ordering is strictly FIFO.
- IDATA, ISHAMT and IROT are sampled only on an input transfer.

## Timing
- Reset, asserted asynchronously: all v_k, d_k, s_k and r_k clear to 0. OVALID = 0 and ODATA = 0 during and after reset.
  - IREADY is 1 during reset, because all stages are empty. Inputs presented during reset are discarded.
- Reset asserted mid-operation flushes every in-flight word. No result appears after RSTN deasserts unless new input is accepted.
- Latency: S cycles from the input-transfer edge to OVALID (5 cycles at the default width).
- Throughput: one word per cycle while OREADY = 1.
- Stall: OREADY = 0 with the pipe full drops IREADY in the same cycle. OREADY = 0 with empty stages leaves IREADY at 1 until the pipe fills.
- Simultaneous output transfer and input transfer on a full pipe: both occur, and the pipe stays full.
- ODATA and OVALID must remain stable while OVALID = 1 and OREADY = 0.
- IREADY has a combinational path from OREADY through the ready chain. This path is intended and is S gates deep.

## Test plan
- Reset / idle:
  - Stimulus: RSTN = 0.
  - Required: OVALID = 0, ODATA = 0x00000000, IREADY = 1.
  - Stimulus: release reset with IVALID = 0 for 10 cycles.
  - Required: OVALID stays 0.
- Logical shift vectors (IROT = 0, OREADY = 1):
  - 0x00000001 shamt 31 -> 0x80000000 exactly 5 cycles later.
  - 0xF0F0F0F0 shamt 4 -> 0x0F0F0F00.
  - 0x12345678 shamt 0 -> 0x12345678.
- Rotate vectors (IROT = 1):
  - 0x80000001 shamt 1 -> 0x00000003.
  - 0xDEADBEEF shamt 16 -> 0xBEEFDEAD.
  - 0x00000001 shamt 31 -> 0x80000000.
- Streaming:
  - Stimulus: 100 back-to-back random words with random shamt and IROT, OREADY = 1.
  - Required: one result per cycle after a 5-cycle fill, in order, each matching the reference model.
- Backpressure:
  - Stimulus: random IVALID and OREADY toggling for 2000 cycles.
  - Required: no loss, duplication or reordering versus a scoreboard. ODATA stable while stalled. IREADY = 0 only when all 5 stages are valid and OREADY = 0.
- Reset mid-flight:
  - Stimulus: assert RSTN = 0 asynchronously (between edges) with 3 words in the pipe.
  - Required: OVALID falls immediately. After release, no stale word is ever output. The first new input emerges after 5 cycles.
